cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Synthesizable run controller and monitor for the single-cycle MIPS core, one instance per CPU.
//  - Sequences the CPU reset.
//  - Counts cycles and retired instructions.
//  - Detects the halt instruction or a cycle-limit timeout.
//  - Buffers register-file writebacks in a trace FIFO for a bench or debug port.
//  Replaces the free-running clock/reset harness with a parametrised, self-terminating one.
// PARAMETERS
//  DW          32            data/instruction/PC width
//  CW          32            cycle_count / retired_count width
//  RST_CYCLES  4             cycles cpu_reset_n is held low after start (>=1)
//  MAX_CYCLES  1000          RUN cycles before timeout (>=2, < 2**CW)
//  HALT_INSN   32'hFC000000  instruction word that ends a run (opcode 6'b111111)
//  TRACE_DEPTH 16            trace FIFO entries, power of two >=2
// PORTS
//  clk           in   1     single clock, rising edge
//  reset         in   1     asynchronous, active-low; all state cleared while 0
//  start         in   1     one-cycle pulse; begins a run from IDLE/DONE/TIMEOUT
//  cpu_reset_n   out  1     drives CPU reset (low = CPU held in reset)
//  pcOut         in   DW    CPU current PC
//  IDataOut      in   DW    CPU current instruction word
//  PCWre         in   1     CPU PC write enable (instruction retires)
//  RegWre        in   1     CPU register-file write enable
//  WriteReg      in   5     CPU destination register
//  writeData     in   DW    CPU writeback data
//  running       out  1     state==RUN
//  done          out  1     state==DONE (halt seen)
//  timeout       out  1     state==TIMEOUT
//  halt_pc       out  DW    PC of the halt instruction
//  cycle_count   out  CW    RUN cycles in current/last run
//  retired_count out  CW    PCWre cycles in RUN, halt cycle excluded
//  trace_valid   out  1     FIFO non-empty
//  trace_ready   in   1     consumer pops when trace_valid & trace_ready
//  trace_data    out  DW+5  {WriteReg, writeData} at FIFO head
//  trace_ovf     out  1     sticky: a writeback was dropped because FIFO full
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, cpu_reset_n=0.
//  - All flags, counters, halt_pc and trace_data = 0.
//  - FIFO empty.
//  FSM:
//  - IDLE -start-> HOLD.
//  - HOLD: cpu_reset_n=0 for exactly RST_CYCLES cycles, then -> RUN.
//  - RUN: cpu_reset_n=1.
//    - Exits to DONE on IDataOut==HALT_INSN: halt_pc<=pcOut, cycle counted, not retired.
//    - Otherwise exits to TIMEOUT when cycle_count reaches MAX_CYCLES.
//    - Halt and timeout in the same cycle: DONE wins.
//  - DONE/TIMEOUT: cpu_reset_n=0; counters, halt_pc, FIFO contents held; -start-> HOLD.
//  - start is ignored in HOLD and RUN.
//  Start from DONE/TIMEOUT (on the HOLD entry edge):
//  - Clears counters, halt_pc and trace_ovf.
//  - Empties the FIFO.
//  Counters:
//  - cycle_count +1 per RUN cycle.
//  - retired_count +1 per RUN cycle with PCWre=1 and no halt.
//  - Both saturate at all-ones.
//  - Unsigned, CW bits.
//  Trace push:
//  - Only in RUN, when RegWre=1 and WriteReg!=0.
//  - Not on the halt cycle.
//  FIFO:
//  - Registered: pushed entry visible on trace_valid/trace_data the cycle after the push edge.
//  - Pop and push in the same cycle are both accepted, including when full; count unchanged.
//  - Full with no pop: push dropped, trace_ovf<=1.
//  - Empty with no push: pop ignored.
//  - Pointers wrap modulo TRACE_DEPTH.
//  - trace_data holds the last head value when empty.
//  Reset asserted mid-run: immediate return to reset values; cpu_reset_n drops asynchronously.
// TESTING
//  - Reset low 3 cycles, release, no start -> IDLE held, cpu_reset_n=0, all outputs 0.
//  - start at t0, RST_CYCLES=4 -> cpu_reset_n low 4 cycles, running=1 on 5th edge; CPU runs 10 ADDs then HALT_INSN at PC 0x28 -> done=1, halt_pc=0x28, cycle_count=11, retired_count=10.
//  - Program loops forever, MAX_CYCLES=50 -> timeout=1 after 50 RUN cycles, cycle_count=50, done=0.
//  - 20 writebacks, TRACE_DEPTH=16, trace_ready=0 -> 16 entries kept in order, trace_ovf=1; then trace_ready=1 -> first entry {5'd1,32'h1} popped first.
//  - FIFO full, push and pop same cycle -> entry accepted, trace_ovf stays 0, occupancy 16; write to $0 -> no push.
//  - Reset pulled low mid-RUN with FIFO holding 5 entries -> IDLE, FIFO empty, counters 0; start after DONE -> counters and trace_ovf cleared.

Source files
------------

// File: rtl/cpu_run_monitor_if.sv
// CPU observation bus and trace stream shared by the run monitor and its consumer.
// The master side is the monitor: it watches the CPU signals and sources the trace stream.
// The slave side is whoever drives the CPU signals and drains the trace.
interface cpu_run_monitor_if #(
  parameter int DW = 32
);
  logic [DW-1:0] pcOut;
  logic [DW-1:0] IDataOut;
  logic          PCWre;
  logic          RegWre;
  logic [4:0]    WriteReg;
  logic [DW-1:0] writeData;
  logic          trace_valid;
  logic          trace_ready;
  logic [DW+4:0] trace_data;
  logic          trace_ovf;

  modport master (
    input  pcOut, IDataOut, PCWre, RegWre, WriteReg, writeData, trace_ready,
    output trace_valid, trace_data, trace_ovf
  );

  modport slave (
    output pcOut, IDataOut, PCWre, RegWre, WriteReg, writeData, trace_ready,
    input  trace_valid, trace_data, trace_ovf
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller and monitor for one single-cycle MIPS core.
// Sequences the CPU reset, counts run cycles and retired instructions,
// stops on the halt instruction or a cycle limit, and queues register
// writebacks in a small trace FIFO for a bench or debug consumer.
module cpu_run_monitor #(
  parameter int            DW          = 32,
  parameter int            CW          = 32,
  parameter int            RST_CYCLES  = 4,
  parameter int            MAX_CYCLES  = 1000,
  parameter logic [DW-1:0] HALT_INSN   = 32'hFC000000,
  parameter int            TRACE_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  cpu_reset_n,
  output logic                  running,
  output logic                  done,
  output logic                  timeout,
  output logic [DW-1:0]         halt_pc,
  output logic [CW-1:0]         cycle_count,
  output logic [CW-1:0]         retired_count,
  cpu_run_monitor_if.master     bus
);

  localparam int AW   = (TRACE_DEPTH > 2) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int HW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [HW-1:0]   HOLD_LAST  = HW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]   CYCLE_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(TRACE_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DONE,
    TIMEOUT
  } stateType;

  stateType        state;
  stateType        stateNext;
  logic [HW-1:0]   holdCnt;
  logic [CW-1:0]   cycleCount;
  logic [CW-1:0]   retiredCount;
  logic [DW-1:0]   haltPc;

  logic            startAccept;
  logic            isRun;
  logic            haltSeen;
  logic            limitHit;

  logic [DW+4:0]   traceMem [TRACE_DEPTH];
  logic [AW-1:0]   rdPtr;
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdNext;
  logic [CNTW-1:0] traceCount;
  logic [CNTW-1:0] remainCount;
  logic [DW+4:0]   traceHead;
  logic [DW+4:0]   headNext;
  logic [DW+4:0]   pushWord;
  logic            headLoad;
  logic            traceOvf;
  logic            pushReq;
  logic            popOk;
  logic            pushOk;

  // Start only counts when the controller is parked; the halt word only matters while running.
  assign startAccept = start && (state == IDLE || state == DONE || state == TIMEOUT);
  assign isRun       = (state == RUN);
  assign haltSeen    = isRun && (bus.IDataOut == HALT_INSN);
  assign limitHit    = isRun && (cycleCount == CYCLE_LAST);

  // The CPU only leaves reset while running, so an async reset drops it straight away.
  assign cpu_reset_n   = isRun;
  assign running       = isRun;
  assign done          = (state == DONE);
  assign timeout       = (state == TIMEOUT);
  assign halt_pc       = haltPc;
  assign cycle_count   = cycleCount;
  assign retired_count = retiredCount;

  // A pop needs something to pop; a push into a full FIFO only fits if the head leaves the same cycle.
  assign pushReq  = isRun && bus.RegWre && (bus.WriteReg != 5'd0) && !haltSeen;
  assign popOk    = bus.trace_ready && (traceCount != '0);
  assign pushOk   = pushReq && ((traceCount != FULL_COUNT) || popOk);
  assign pushWord = {bus.WriteReg, bus.writeData};

  assign bus.trace_valid = (traceCount != '0);
  assign bus.trace_data  = traceHead;
  assign bus.trace_ovf   = traceOvf;

  // Next state: halt beats the cycle limit when both land on the same cycle.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, DONE, TIMEOUT: if (start) stateNext = HOLD;
      HOLD:                if (holdCnt == HOLD_LAST) stateNext = RUN;
      RUN: begin
        if (haltSeen)      stateNext = DONE;
        else if (limitHit) stateNext = TIMEOUT;
      end
      default:             stateNext = IDLE;
    endcase
  end

  // State register plus the counter that times how long the CPU is held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      holdCnt <= '0;
    end else begin
      state <= stateNext;
      if (startAccept)        holdCnt <= '0;
      else if (state == HOLD) holdCnt <= holdCnt + HW'(1);
    end
  end

  // Run statistics and halt PC, cleared by each new start and frozen outside RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycleCount   <= '0;
      retiredCount <= '0;
      haltPc       <= '0;
    end else if (startAccept) begin
      cycleCount   <= '0;
      retiredCount <= '0;
      haltPc       <= '0;
    end else if (isRun) begin
      if (cycleCount != '1) cycleCount <= cycleCount + CW'(1);
      if (haltSeen) haltPc <= bus.pcOut;
      else if (bus.PCWre && (retiredCount != '1)) retiredCount <= retiredCount + CW'(1);
    end
  end

  // Head register source: the word being pushed if the FIFO would otherwise be empty, else the next stored entry.
  always_comb begin
    rdNext      = popOk ? (rdPtr + AW'(1)) : rdPtr;
    remainCount = traceCount - CNTW'(popOk);
    headLoad    = 1'b0;
    headNext    = traceHead;
    if (pushOk && (remainCount == '0)) begin
      headLoad = 1'b1;
      headNext = pushWord;
    end else if (remainCount != '0) begin
      headLoad = 1'b1;
      headNext = traceMem[rdNext];
    end
  end

  // Trace storage itself needs no reset because nothing reads an empty slot.
  always_ff @(posedge clk) begin
    if (pushOk) traceMem[wrPtr] <= pushWord;
  end

  // FIFO pointers, occupancy, registered head and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      traceCount <= '0;
      traceHead  <= '0;
      traceOvf   <= 1'b0;
    end else if (startAccept) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      traceCount <= '0;
      traceOvf   <= 1'b0;
    end else begin
      rdPtr      <= rdNext;
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      traceCount <= traceCount + CNTW'(pushOk) - CNTW'(popOk);
      if (headLoad) traceHead <= headNext;
      if (pushReq && !pushOk) traceOvf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed run scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model of the run monitor.
module tb_cpu_run_monitor;

  localparam int            DW          = 32;
  localparam int            CW          = 32;
  localparam int            RST_CYCLES  = 4;
  localparam int            MAX_CYCLES  = 50;
  localparam logic [DW-1:0] HALT        = 32'hFC000000;
  localparam int            DEPTH       = 16;
  localparam logic [DW-1:0] ADD_INSN    = 32'h00221820;
  localparam logic [DW-1:0] LOOP_INSN   = 32'h1000FFFF;

  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3, P_TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cpu_reset_n;
  logic          running;
  logic          done;
  logic          timeout;
  logic [DW-1:0] halt_pc;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] retired_count;

  int assertCount = 0;
  int failCount   = 0;

  cpu_run_monitor_if #(.DW(DW)) bus ();

  cpu_run_monitor #(
    .DW(DW), .CW(CW), .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .HALT_INSN(HALT), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cpu_reset_n(cpu_reset_n),
    .running(running),
    .done(done),
    .timeout(timeout),
    .halt_pc(halt_pc),
    .cycle_count(cycle_count),
    .retired_count(retired_count),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int            mPhase   = P_IDLE;
  int            holdLeft = 0;
  logic [CW-1:0] mCyc     = '0;
  logic [CW-1:0] mRet     = '0;
  logic [DW-1:0] mHaltPc  = '0;
  logic          mOvf     = 1'b0;
  logic [DW+4:0] mHead    = '0;
  logic [DW+4:0] mFifo[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic parked, halt, push, popOk, room;
    if (!reset) begin
      mPhase = P_IDLE; holdLeft = 0; mCyc = '0; mRet = '0; mHaltPc = '0;
      mOvf = 1'b0; mHead = '0; mFifo.delete();
      return;
    end
    parked = (mPhase == P_IDLE) || (mPhase == P_DONE) || (mPhase == P_TIMEOUT);
    halt   = (mPhase == P_RUN) && (bus.IDataOut == HALT);
    push   = (mPhase == P_RUN) && bus.RegWre && (bus.WriteReg != 0) && !halt;
    if (parked && start) begin
      mPhase = P_HOLD; holdLeft = RST_CYCLES;
      mCyc = '0; mRet = '0; mHaltPc = '0; mOvf = 1'b0; mFifo.delete();
      return;
    end
    if (mPhase == P_HOLD) begin
      holdLeft--;
      if (holdLeft == 0) mPhase = P_RUN;
    end else if (mPhase == P_RUN) begin
      if (mCyc != '1) mCyc++;
      if (halt) begin
        mPhase  = P_DONE;
        mHaltPc = bus.pcOut;
      end else begin
        if (bus.PCWre && mRet != '1) mRet++;
        if (mCyc == CW'(MAX_CYCLES)) mPhase = P_TIMEOUT;
      end
    end
    popOk = bus.trace_ready && (mFifo.size() > 0);
    room  = (mFifo.size() < DEPTH) || popOk;
    if (push && !room) mOvf = 1'b1;
    if (popOk) void'(mFifo.pop_front());
    if (push && room) mFifo.push_back({bus.WriteReg, bus.writeData});
    if (mFifo.size() > 0) mHead = mFifo[0];
  endtask

  // Model follows every clock edge and the asynchronous reset
  always @(posedge clk or negedge reset) modelStep();

  // Compare every DUT output with the model on each falling edge
  always @(negedge clk) begin
    checkOutput("cpu_reset_n", cpu_reset_n, mPhase == P_RUN);
    checkOutput("running", running, mPhase == P_RUN);
    checkOutput("done", done, mPhase == P_DONE);
    checkOutput("timeout", timeout, mPhase == P_TIMEOUT);
    checkOutput("halt_pc", halt_pc, mHaltPc);
    checkOutput("cycle_count", cycle_count, mCyc);
    checkOutput("retired_count", retired_count, mRet);
    checkOutput("trace_valid", bus.trace_valid, mFifo.size() > 0);
    checkOutput("trace_data", bus.trace_data, mHead);
    checkOutput("trace_ovf", bus.trace_ovf, mOvf);
  end

  task automatic applyStimulus(input logic st, input logic [DW-1:0] pc, input logic [DW-1:0] insn,
                               input logic pcw, input logic rw, input logic [4:0] wr,
                               input logic [DW-1:0] wd, input logic rdy);
    start           = st;
    bus.pcOut       = pc;
    bus.IDataOut    = insn;
    bus.PCWre       = pcw;
    bus.RegWre      = rw;
    bus.WriteReg    = wr;
    bus.writeData   = wd;
    bus.trace_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, rdy);
  endtask

  initial begin
    logic [DW+4:0] entry;
    int runCycles;
    int popped;
    int readyBias;

    start = 1'b0;
    bus.pcOut = '0; bus.IDataOut = ADD_INSN; bus.PCWre = 1'b0; bus.RegWre = 1'b0;
    bus.WriteReg = '0; bus.writeData = '0; bus.trace_ready = 1'b0;

    // Reset for three cycles, then idle without start
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idleCycles(3, 1'b0);
    checkOutput("idle_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("idle_running", running, 0);
    checkOutput("idle_cycles", cycle_count, 0);
    checkOutput("idle_trace_data", bus.trace_data, 0);

    // Reset sequencing then ten ADDs and a halt at 0x28
    $display("[TB] directed: halt run");
    applyStimulus(1'b1, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, 1'b1);
    checkOutput("hold_cpu_reset_n_1", cpu_reset_n, 0);
    for (int k = 2; k <= 5; k++) begin
      idleCycles(1, 1'b1);
      checkOutput("hold_running", running, k == 5);
    end
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, DW'(4 * i), ADD_INSN, 1'b1, 1'b1, 5'd3, DW'(i), 1'b1);
    applyStimulus(1'b0, 32'h28, HALT, 1'b1, 1'b1, 5'd4, 32'h77, 1'b1);
    checkOutput("halt_done", done, 1);
    checkOutput("halt_pc_lit", halt_pc, 32'h28);
    checkOutput("halt_cycles", cycle_count, 11);
    checkOutput("halt_retired", retired_count, 10);
    idleCycles(2, 1'b1);

    // Endless loop until the cycle limit
    $display("[TB] directed: timeout run");
    applyStimulus(1'b1, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, 1'b1);
    idleCycles(4, 1'b1);
    runCycles = 0;
    while (!timeout && runCycles < 200) begin
      applyStimulus(1'b0, 32'h100, LOOP_INSN, 1'b1, 1'b0, 5'd0, '0, 1'b1);
      runCycles++;
    end
    checkOutput("to_flag", timeout, 1);
    checkOutput("to_run_cycles", runCycles, 50);
    checkOutput("to_cycles", cycle_count, 50);
    checkOutput("to_done", done, 0);

    // Twenty writebacks into a sixteen-deep FIFO with no consumer
    $display("[TB] directed: overflow");
    applyStimulus(1'b1, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, 1'b0);
    idleCycles(4, 1'b0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, DW'(4 * i), ADD_INSN, 1'b1, 1'b1, 5'(i + 1), DW'(i + 1), 1'b0);
    applyStimulus(1'b0, 32'h50, HALT, 1'b1, 1'b1, 5'd7, 32'h99, 1'b0);
    checkOutput("ovf_flag", bus.trace_ovf, 1);
    entry = {5'd1, 32'h1};
    checkOutput("ovf_first", bus.trace_data, entry);
    for (int k = 0; k < DEPTH; k++) begin
      entry = {5'(k + 1), 32'(k + 1)};
      checkOutput("ovf_order", bus.trace_data, entry);
      idleCycles(1, 1'b1);
    end
    checkOutput("ovf_drained", bus.trace_valid, 0);

    // Full FIFO with simultaneous push and pop, then a write to $0
    $display("[TB] directed: push and pop when full");
    applyStimulus(1'b1, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("restart_ovf", bus.trace_ovf, 0);
    checkOutput("restart_cycles", cycle_count, 0);
    checkOutput("restart_halt_pc", halt_pc, 0);
    idleCycles(4, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, DW'(4 * i), ADD_INSN, 1'b1, 1'b1, 5'(i + 1), DW'(32'h100 + i), 1'b0);
    applyStimulus(1'b0, 32'h40, ADD_INSN, 1'b1, 1'b1, 5'd20, 32'hABCD, 1'b1);
    applyStimulus(1'b0, 32'h44, ADD_INSN, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    applyStimulus(1'b0, 32'h48, HALT, 1'b1, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("full_ovf", bus.trace_ovf, 0);
    entry = {5'd2, 32'h101};
    checkOutput("full_head", bus.trace_data, entry);
    popped = 0;
    while (bus.trace_valid && popped < 40) begin
      idleCycles(1, 1'b1);
      popped++;
    end
    checkOutput("full_occupancy", popped, DEPTH);

    // Asynchronous reset in the middle of a run with five entries queued
    $display("[TB] directed: reset mid-run");
    applyStimulus(1'b1, '0, ADD_INSN, 1'b0, 1'b0, 5'd0, '0, 1'b0);
    idleCycles(4, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, DW'(4 * i), ADD_INSN, 1'b1, 1'b1, 5'(i + 9), DW'(i), 1'b0);
    idleCycles(2, 1'b0);
    checkOutput("mid_valid", bus.trace_valid, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_cpu_reset_n", cpu_reset_n, 0);
    checkOutput("async_valid", bus.trace_valid, 0);
    checkOutput("async_cycles", cycle_count, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model
    $display("[TB] random phase");
    readyBias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) readyBias = $urandom_range(0, 4);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
      end else begin
        applyStimulus($urandom_range(0, 15) == 0, $urandom,
                      ($urandom_range(0, 29) == 0) ? HALT : $urandom,
                      1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                      $urandom_range(0, 3) < readyBias);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
